// File: rtl/uart_word_loader.sv
// uart_word_loader: packs received UART bytes into 32-bit words and writes them
// to consecutive RAM addresses starting from a programmable base.
module uart_word_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  input  logic                  set_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  err_clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic                  timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
  state_t state, state_n;
  logic [1:0] idx, eff_idx, lane;
  logic [TW-1:0] tcnt;
  logic [31:0] word, word_n;
  logic [ADDR_WIDTH-1:0] ptr;
  logic tmo;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // set_addr restarts the word, so a coincident byte always lands as byte 0
  always_comb begin
    eff_idx = set_addr ? 2'd0 : idx;
    tmo = state == COLLECT && !rx_valid && !set_addr && tcnt == TW'(TIMEOUT_CYCLES - 1);
    state_n = rx_valid ? (eff_idx == 2'd3 ? WRITE : COLLECT) :
              (set_addr || tmo || state == WRITE) ? IDLE : state;
  end
  always_comb begin
    wr_en = state == WRITE;
    busy = state == COLLECT;
  end
  always_comb begin
    lane = BIG_ENDIAN ? 2'd3 - eff_idx : eff_idx;
    word_n = word;
    word_n[lane*8 +: 8] = rx_byte;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      tcnt <= '0;
      word <= '0;
      ptr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      word_count <= '0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      idx <= rx_valid ? eff_idx + 2'd1 : (set_addr || tmo) ? 2'd0 : idx;
      tcnt <= (rx_valid || set_addr || tmo || state != COLLECT) ? '0 : tcnt + TW'(1);
      if (rx_valid) word <= word_n;
      if (rx_valid && eff_idx == 2'd3) begin
        wr_addr <= ptr;
        wr_data <= word_n;
      end
      if (set_addr) begin
        ptr <= start_addr;
        word_count <= '0;
      end else if (state == WRITE) begin
        ptr <= ptr + ADDR_WIDTH'(1);
        if (word_count != '1) word_count <= word_count + (ADDR_WIDTH+1)'(1);
      end
      if (state == WRITE && !set_addr && ptr == '1) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (tmo) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: scenario tasks plus randomized streams against a byte-queue model.
module tb_uart_word_loader;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic reset, rx_valid, set_addr, err_clr;
  logic [7:0] rx_byte;
  logic [AW-1:0] start_addr;
  logic wr_en, busy, overflow, timeout_err;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [AW:0] word_count;
  int checks = 0, errors = 0;
  logic [AW-1:0] obs_a[$];
  logic [31:0] obs_d[$];
  always #5 clk = ~clk;
  uart_word_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .BIG_ENDIAN(1)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .set_addr(set_addr), .start_addr(start_addr), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .word_count(word_count), .overflow(overflow), .timeout_err(timeout_err)
  );
  always @(negedge clk)
    if (wr_en) begin
      obs_a.push_back(wr_addr);
      obs_d.push_back(wr_data);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask
  task automatic load(input logic [AW-1:0] a);
    start_addr = a;
    set_addr = 1'b1;
    step();
    set_addr = 1'b0;
  endtask
  task automatic clear_obs();
    obs_a.delete();
    obs_d.delete();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, word_count, overflow, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b a=%h d=%h busy=%b wc=%0d ov=%b to=%b, expected all 0",
               wr_en, wr_addr, wr_data, busy, word_count, overflow, timeout_err);
    end
  endtask
  task automatic test_big_endian();
    load(12'h010);
    send(8'hDE); send(8'hAD); send(8'hBE);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL be_busy_mid: got %b, expected 1", busy); end
    send(8'hEF);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'h010, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL be_write: got en=%b a=%h d=%h, expected en=1 a=010 d=deadbeef", wr_en, wr_addr, wr_data);
    end
    step();
    checks++;
    if ({word_count, busy, wr_en} !== {13'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL be_after: got wc=%0d busy=%b en=%b, expected wc=1 busy=0 en=0", word_count, busy, wr_en);
    end
    checks++;
    if ({wr_addr, wr_data} !== {12'h010, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL be_hold: got a=%h d=%h, expected a=010 d=deadbeef", wr_addr, wr_data);
    end
  endtask
  task automatic test_back_to_back();
    load(12'h000);
    clear_obs();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_byte = 8'(i + 1);
      step();
    end
    rx_valid = 1'b0;
    step();
    checks++;
    if (obs_a.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, expected 2", obs_a.size());
    end else begin
      checks++;
      if ({obs_a[0], obs_d[0], obs_a[1], obs_d[1]} !== {12'h000, 32'h01020304, 12'h001, 32'h05060708}) begin
        errors++;
        $display("FAIL b2b_data: got %h@%h %h@%h, expected 01020304@000 05060708@001",
                 obs_d[0], obs_a[0], obs_d[1], obs_a[1]);
      end
    end
  endtask
  task automatic test_timeout();
    load(12'h020);
    clear_obs();
    send(8'hAA); send(8'hBB);
    repeat (15) step();
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL to_early: got to=%b busy=%b after 15 idle, expected to=0 busy=1", timeout_err, busy);
    end
    step();
    checks++;
    if ({timeout_err, busy, obs_a.size() == 0} !== 3'b101) begin
      errors++;
      $display("FAIL to_fire: got to=%b busy=%b writes=%0d, expected to=1 busy=0 writes=0",
               timeout_err, busy, obs_a.size());
    end
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    step();
    checks++;
    if (obs_a.size() != 1 || obs_a[0] !== 12'h020 || obs_d[0] !== 32'h11223344) begin
      errors++;
      $display("FAIL to_resume: got %0d writes first %h@%h, expected 11223344@020",
               obs_a.size(), obs_d[0], obs_a[0]);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b, expected 0", timeout_err); end
  endtask
  task automatic test_wrap();
    load(12'hFFF);
    clear_obs();
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    step();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ov: got %b, expected 1", overflow); end
    send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
    step();
    checks++;
    if (obs_a.size() != 2 || obs_a[0] !== 12'hFFF || obs_d[0] !== 32'hC0C1C2C3 ||
        obs_a[1] !== 12'h000 || obs_d[1] !== 32'hD0D1D2D3) begin
      errors++;
      $display("FAIL wrap_writes: got %0d writes %h@%h %h@%h, expected c0c1c2c3@fff d0d1d2d3@000",
               obs_a.size(), obs_d[0], obs_a[0], obs_d[1], obs_a[1]);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if ({overflow, word_count} !== {1'b0, 13'd2}) begin
      errors++;
      $display("FAIL wrap_clr: got ov=%b wc=%0d, expected ov=0 wc=2", overflow, word_count);
    end
  endtask
  task automatic test_collision();
    load(12'h040);
    clear_obs();
    send(8'h12); send(8'h34);
    start_addr = 12'h100;
    set_addr = 1'b1;
    send(8'h55);
    set_addr = 1'b0;
    send(8'h66); send(8'h77); send(8'h88);
    step();
    checks++;
    if (obs_a.size() != 1 || obs_a[0] !== 12'h100 || obs_d[0] !== 32'h55667788) begin
      errors++;
      $display("FAIL coll_write: got %0d writes first %h@%h, expected 55667788@100",
               obs_a.size(), obs_d[0], obs_a[0]);
    end
    checks++;
    if ({timeout_err, word_count} !== {1'b0, 13'd1}) begin
      errors++;
      $display("FAIL coll_flags: got to=%b wc=%0d, expected to=0 wc=1", timeout_err, word_count);
    end
  endtask
  task automatic test_reset_mid_word();
    load(12'h055);
    send(8'h01); send(8'h02); send(8'h03);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_obs();
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, word_count, overflow, timeout_err} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got en=%b a=%h d=%h busy=%b wc=%0d, expected all 0",
               wr_en, wr_addr, wr_data, busy, word_count);
    end
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    step();
    checks++;
    if (obs_a.size() != 1 || obs_a[0] !== 12'h000 || obs_d[0] !== 32'hA1A2A3A4) begin
      errors++;
      $display("FAIL midrst_write: got %0d writes first %h@%h, expected a1a2a3a4@000",
               obs_a.size(), obs_d[0], obs_a[0]);
    end
  endtask
  task automatic test_random(input int lo);
    logic [7:0] b[$];
    int n, sa;
    logic exp_ov;
    n = 12;
    sa = $urandom_range(4095, lo);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    load(AW'(sa));
    clear_obs();
    for (int i = 0; i < 4 * n; i++) begin
      b.push_back(8'($urandom));
      send(b[i]);
      repeat ($urandom_range(3, 0)) step();
    end
    step();
    checks++;
    if (obs_a.size() != n) begin
      errors++;
      $display("FAIL rand_count: got %0d writes, expected %0d", obs_a.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_a[k] !== AW'(sa + k) || obs_d[k] !== {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]}) begin
          errors++;
          $display("FAIL rand_word%0d: got %h@%h, expected %h@%h", k, obs_d[k], obs_a[k],
                   {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]}, AW'(sa + k));
        end
      end
    end
    exp_ov = (sa + n >= 4096);
    checks++;
    if ({word_count, overflow} !== {13'(n), exp_ov}) begin
      errors++;
      $display("FAIL rand_status: got wc=%0d ov=%b, expected wc=%0d ov=%b", word_count, overflow, n, exp_ov);
    end
  endtask
  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    set_addr = 1'b0;
    err_clr = 1'b0;
    rx_byte = '0;
    start_addr = '0;
    test_reset();
    test_big_endian();
    test_back_to_back();
    test_timeout();
    test_wrap();
    test_collision();
    test_reset_mid_word();
    test_random(0);
    test_random(4080);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Sits between the byte-level UART receiver and the RAM second write port (wEn2/addr2/dataIn2).
- Assembles received serial bytes into 32-bit words and writes them to consecutive RAM addresses from a programmable start address.
- The processor loads programs and data over serial through this block without stalling.
- The start address and address-load strobe come from the memory map.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width.
- TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between bytes of one word before the partial word is discarded.
- BIG_ENDIAN, 1: 1 = first received byte goes to wr_data[31:24]; 0 = first byte goes to wr_data[7:0].

Ports:
- clk  input  1  system clock (the same 100 MHz board clock the UART receiver uses).
- reset  input  1  synchronous, active-high reset.
- rx_byte  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle.
- set_addr  input  1  one-cycle strobe; load start_addr as the next write address.
- start_addr  input  ADDR_WIDTH  start word address.
- err_clr  input  1  clears the sticky error flags.
- wr_en  output  1  RAM write enable, one-cycle pulse.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- wr_data  output  32  RAM write data.
- busy  output  1  a partial word (1-3 bytes) is held.
- word_count  output  ADDR_WIDTH+1  words written since the last set_addr or reset; saturates at all-ones.
- overflow  output  1  sticky; a write went to the last address and the pointer wrapped to 0.
- timeout_err  output  1  sticky; a partial word was discarded because of a timeout.

Behaviour:
- Reset state (synchronous, active-high): all outputs 0, write pointer 0, byte index 0, timeout counter 0, state IDLE.
- States:
  - IDLE: byte index 0.
  - COLLECT: byte index 1..3.
  - WRITE: exactly one cycle.
- Byte acceptance: on rx_valid in IDLE or COLLECT, rx_byte is stored in lane index (per BIG_ENDIAN), the index increments and the timeout counter clears.
  - IDLE -> COLLECT on the 1st byte.
  - COLLECT -> WRITE on the 4th byte.
- WRITE cycle (the cycle after the 4th rx_valid; latency 1):
  - wr_en=1, wr_addr=pointer, wr_data=assembled word.
  - Next cycle: pointer+1 modulo 2^ADDR_WIDTH, word_count+1 (saturating), state -> IDLE.
  - An rx_valid arriving during WRITE is accepted as byte 0 of the next word; state goes to COLLECT with index 1. No byte is lost at any sustained input rate.
- wr_addr and wr_data hold their last values when wr_en=0.
- Wrap-around: a write at address 2^ADDR_WIDTH-1 sets overflow and the pointer wraps to 0. Writing continues.
- Timeout: in COLLECT, the counter increments each cycle without rx_valid. When it reaches TIMEOUT_CYCLES-1:
  - partial word discarded, index 0, state -> IDLE;
  - timeout_err set; no write occurs.
- set_addr:
  - Any state except WRITE: pointer <= start_addr, word_count <= 0, partial word discarded. It does not set timeout_err.
  - Simultaneous with rx_valid: set_addr applies first, and the byte becomes byte 0 of a new word at start_addr.
  - During WRITE: the write completes to the old pointer, then pointer <= start_addr (no increment) and word_count <= 0.
- err_clr: clears overflow and timeout_err next cycle. If a set event occurs in the same cycle, set wins.
- busy = (state == COLLECT).
- Reset mid-word: everything returns to the reset state with no write.

Test Plan:
- Big-endian word: set_addr with start_addr=0x010, then bytes DE AD BE EF -> one cycle after EF: wr_en=1, wr_addr=0x010, wr_data=0xDEADBEEF; word_count=1; busy=0.
- Back-to-back bytes: rx_valid every cycle for 8 bytes 01..08 from address 0x000 -> writes 0x01020304@0x000 and 0x05060708@0x001; the 5th byte, arriving during WRITE, is not lost.
- Timeout: TIMEOUT_CYCLES=16, bytes AA BB, then 16 idle cycles -> timeout_err=1, busy=0, no wr_en. Then 11 22 33 44 -> 0x11223344 written at the unchanged pointer.
- Wrap: start_addr=0xFFF, two words -> writes at 0xFFF then 0x000; overflow=1 after the first write. err_clr -> overflow=0.
- set_addr collision: after 2 bytes, set_addr (start_addr=0x100) together with byte 0x55, then 66 77 88 -> 0x55667788@0x100; timeout_err stays 0.
- Reset mid-word: 3 bytes, then reset for 1 cycle -> all outputs 0. The following 4 bytes write to address 0x000.
